// File: rtl/game_tile_writer_pkg.sv
// game_pkg: shared definitions for the game write stage and the display-side tile mapper.
//   state_t      - write-stage FSM encoding (2 bits)
//   N_TILES      - number of cursor slots on the 4x4 grid
//   TILE_ADDR    - slot -> frame-buffer address map, row-major, single source for both sides
//   RED/GREEN/BLUE/BLACK - RGB222 colour constants {R[1:0],G[1:0],B[1:0]}
package game_pkg;

  typedef enum logic [1:0] {
    StClear = 2'd0,
    StIdle  = 2'd1,
    StErase = 2'd2,
    StDraw  = 2'd3
  } state_t;

  localparam int unsigned N_TILES = 16;

  localparam logic [5:0] BLACK = 6'b000000;
  localparam logic [5:0] RED   = 6'b110000;
  localparam logic [5:0] GREEN = 6'b001100;
  localparam logic [5:0] BLUE  = 6'b000011;

  // Element 0 is the rightmost entry. Slots 0 and 12 deliberately share address 0.
  localparam logic [N_TILES-1:0][5:0] TILE_ADDR = {
    6'd63, 6'd24, 6'd15, 6'd0,
    6'd30, 6'd5,  6'd46, 6'd34,
    6'd17, 6'd52, 6'd12, 6'd1,
    6'd40, 6'd55, 6'd16, 6'd0
  };

  function automatic logic [5:0] tile_addr(input logic [3:0] slot);
    return TILE_ADDR[slot];
  endfunction

endpackage

// File: rtl/game_tile_writer_if.sv
// game_tile_writer_if: frame-buffer write port plus busy status.
//   mem_px_addr - RAM write address (AW bits)
//   mem_px_data - RAM write data, RGB222 (DW bits)
//   px_wr       - write strobe, one word per cycle while high
//   busy        - writer is clearing/erasing/drawing
// master: driven by the writer; slave: seen by the RAM port / observer.
interface game_tile_writer_if #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 6
);
  logic [AW-1:0] mem_px_addr;
  logic [DW-1:0] mem_px_data;
  logic          px_wr;
  logic          busy;

  modport master (
    output mem_px_addr,
    output mem_px_data,
    output px_wr,
    output busy
  );

  modport slave (
    input mem_px_addr,
    input mem_px_data,
    input px_wr,
    input busy
  );
endinterface

// File: rtl/game_tile_writer_btn_debounce.sv
// btn_debounce: raw asynchronous button -> 2-flop synchronizer -> debounced level -> press pulse.
//   clk    - pixel clock
//   rst    - asynchronous reset, active-high (counter cleared, level 0)
//   btn    - raw button input, asynchronous
//   level  - debounced level, changes after DEB_CYCLES consecutive differing samples
//   press  - registered 1-cycle pulse on each rising edge of level
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press
);
  localparam int unsigned CntW = $clog2(DEB_CYCLES + 1);

  logic            sync1_q, sync2_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            press_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  // Counter only runs while the synced sample disagrees with the level; any agreeing
  // sample restarts it, so the level needs DEB_CYCLES disagreeing samples in a row.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CntW'(DEB_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= level_d & ~level_q;
    end
  end

  assign level = level_q;
  assign press = press_q;
endmodule

// File: rtl/game_tile_writer.sv
// game_tile_writer: game-logic write stage for the display frame-buffer RAM.
// Clears all 2^AW words to BG_COLOR after reset, draws the cursor at slot 0, then moves the
// cursor over the 4x4 grid on debounced btnr/btnl presses (erase old tile, draw new tile).
//   clk     - 25 MHz pixel clock (same domain as the RAM write port)
//   rst     - asynchronous reset, active-high
//   btnr    - raw right button, asynchronous, active-high
//   btnl    - raw left button, asynchronous, active-high
//   wr_port - master side of game_tile_writer_if (mem_px_addr, mem_px_data, px_wr, busy)
// Build option: define GAME_TRAIL_EN to erase with TRAIL_COLOR (visited tiles leave a trail);
// otherwise erase uses BG_COLOR.
module game_tile_writer
  import game_pkg::*;
#(
  parameter int unsigned    AW           = 6,
  parameter int unsigned    DW           = 6,
  parameter int unsigned    DEB_CYCLES   = 250000,
  parameter logic [DW-1:0]  BG_COLOR     = 6'b000000,
  parameter logic [DW-1:0]  CURSOR_COLOR = 6'b110000,
  parameter logic [DW-1:0]  TRAIL_COLOR  = 6'b000011
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btnr,
  input  logic                btnl,
  game_tile_writer_if.master  wr_port
);

`ifdef GAME_TRAIL_EN
  localparam logic [DW-1:0] EraseColor = TRAIL_COLOR;
`else
  localparam logic [DW-1:0] EraseColor = BG_COLOR;
`endif

  logic press_r, press_l;
  logic level_r, level_l;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_r (
    .clk   (clk),
    .rst   (rst),
    .btn   (btnr),
    .level (level_r),
    .press (press_r)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_l (
    .clk   (clk),
    .rst   (rst),
    .btn   (btnl),
    .level (level_l),
    .press (press_l)
  );

  // state_q names the write currently on the registered outputs; the next-state logic
  // therefore also computes the next registered output values.
  state_t        state_q, state_d;
  logic [AW:0]   clr_q, clr_d;     // MSB set once the last clear word has been issued
  logic [3:0]    cursor_q, cursor_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          wr_q, wr_d;
  logic          busy_q, busy_d;

  always_comb begin
    state_d  = state_q;
    clr_d    = clr_q;
    cursor_d = cursor_q;
    addr_d   = addr_q;
    data_d   = data_q;
    wr_d     = 1'b0;
    busy_d   = 1'b1;
    unique case (state_q)
      StClear: begin
        wr_d = 1'b1;
        if (clr_q[AW]) begin
          addr_d  = AW'(tile_addr(cursor_q));
          data_d  = CURSOR_COLOR;
          state_d = StDraw;
        end else begin
          addr_d = clr_q[AW-1:0];
          data_d = BG_COLOR;
          clr_d  = clr_q + 1'b1;
        end
      end
      StIdle: begin
        busy_d = 1'b0;
        // Both pulses in the same cycle cancel out: no move, no write.
        if (press_r ^ press_l) begin
          wr_d     = 1'b1;
          busy_d   = 1'b1;
          addr_d   = AW'(tile_addr(cursor_q));
          data_d   = EraseColor;
          cursor_d = press_r ? cursor_q + 4'd1 : cursor_q - 4'd1;
          state_d  = StErase;
        end
      end
      StErase: begin
        wr_d    = 1'b1;
        addr_d  = AW'(tile_addr(cursor_q));
        data_d  = CURSOR_COLOR;
        state_d = StDraw;
      end
      StDraw: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StClear;
      clr_q    <= '0;
      cursor_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      wr_q     <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      clr_q    <= clr_d;
      cursor_q <= cursor_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      wr_q     <= wr_d;
      busy_q   <= busy_d;
    end
  end

  assign wr_port.mem_px_addr = addr_q;
  assign wr_port.mem_px_data = data_q;
  assign wr_port.px_wr       = wr_q;
  assign wr_port.busy        = busy_q;
endmodule

// File: tb/tb_game_tile_writer.sv
module tb_game_tile_writer;
  localparam int unsigned DEB = 4;
  localparam logic [5:0] RED_C = 6'b110000;
  localparam logic [5:0] BG_C  = 6'b000000;
`ifdef GAME_TRAIL_EN
  localparam logic [5:0] ERASE_C = 6'b000011;
`else
  localparam logic [5:0] ERASE_C = 6'b000000;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btnr = 1'b0;
  logic btnl = 1'b0;
  always #5 clk = ~clk;

  game_tile_writer_if #(.AW(6), .DW(6)) bus ();

  game_tile_writer #(.AW(6), .DW(6), .DEB_CYCLES(DEB)) dut (
    .clk     (clk),
    .rst     (rst),
    .btnr    (btnr),
    .btnl    (btnl),
    .wr_port (bus)
  );

  typedef struct {
    logic [5:0] addr;
    logic [5:0] data;
  } wr_t;

  typedef struct {
    bit r;
    bit l;
    int hold;
    int exp_slot;
  } vec_t;

  int tile_map [16] = '{0, 16, 55, 40, 1, 12, 52, 17, 34, 46, 5, 30, 0, 15, 24, 63};

  wr_t        exp_q [$];
  logic [5:0] ram [64];
  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  int cursor = 0;

  // Scoreboard: every DUT write must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (!rst && bus.px_wr === 1'b1) begin
      wr_cnt++;
      ram[bus.mem_px_addr] = bus.mem_px_data;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL write_unexpected: got addr=%0d data=%b, required no write",
                 bus.mem_px_addr, bus.mem_px_data);
      end else begin
        e = exp_q.pop_front();
        if (e.addr !== bus.mem_px_addr || e.data !== bus.mem_px_data) begin
          bad++;
          $display("FAIL write_seq: got addr=%0d data=%b, required addr=%0d data=%b",
                   bus.mem_px_addr, bus.mem_px_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic push_wr(input int addr, input logic [5:0] data);
    wr_t w;
    w.addr = 6'(addr);
    w.data = data;
    exp_q.push_back(w);
  endtask

  task automatic push_clear();
    for (int a = 0; a < 64; a++) push_wr(a, BG_C);
    push_wr(0, RED_C);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_addr"}, {26'd0, bus.mem_px_addr}, 32'd0);
    check({tag, "_data"}, {26'd0, bus.mem_px_data}, 32'd0);
    check({tag, "_wr"}, {31'd0, bus.px_wr}, 32'd0);
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
  endtask

  vec_t vecs [7];

  initial begin
    int n;
    int start;
    int prev;
    bit moves;

    vecs[0] = '{r: 1'b1, l: 1'b0, hold: 10, exp_slot: 1};
    vecs[1] = '{r: 1'b0, l: 1'b1, hold: 8,  exp_slot: 0};
    vecs[2] = '{r: 1'b0, l: 1'b1, hold: 8,  exp_slot: 15};
    vecs[3] = '{r: 1'b1, l: 1'b0, hold: 8,  exp_slot: 0};
    vecs[4] = '{r: 1'b1, l: 1'b1, hold: 10, exp_slot: 0};
    vecs[5] = '{r: 1'b1, l: 1'b0, hold: 8,  exp_slot: 1};
    vecs[6] = '{r: 1'b1, l: 1'b0, hold: 8,  exp_slot: 2};

    // Reset values, then the clear sweep with a btnr press that must be dropped.
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    push_clear();
    cursor = 0;
    rst  = 1'b0;
    btnr = 1'b1;
    n = 0;
    while (bus.busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 10) btnr = 1'b0;
    end
    check("clear_busy_fall_cycle", n, 66);
    check("clear_queue_empty", exp_q.size(), 0);
    check("clear_ram_slot0", {26'd0, ram[0]}, {26'd0, RED_C});

    // Table of single presses.
    for (int i = 0; i < 7; i++) begin
      prev  = cursor;
      moves = (vecs[i].exp_slot != cursor);
      start = wr_cnt;
      if (moves) begin
        push_wr(tile_map[prev], ERASE_C);
        push_wr(tile_map[vecs[i].exp_slot], RED_C);
      end
      @(negedge clk);
      btnr = vecs[i].r;
      btnl = vecs[i].l;
      repeat (vecs[i].hold) @(negedge clk);
      btnr = 1'b0;
      btnl = 1'b0;
      repeat (14) @(negedge clk);
      wait_idle();
      check($sformatf("vec%0d_write_count", i), wr_cnt - start, moves ? 2 : 0);
      check($sformatf("vec%0d_queue_empty", i), exp_q.size(), 0);
      if (moves) begin
        check($sformatf("vec%0d_ram_cursor", i), {26'd0, ram[tile_map[vecs[i].exp_slot]]},
              {26'd0, RED_C});
        if (tile_map[prev] != tile_map[vecs[i].exp_slot])
          check($sformatf("vec%0d_ram_erased", i), {26'd0, ram[tile_map[prev]]},
                {26'd0, ERASE_C});
      end
      cursor = vecs[i].exp_slot;
    end

    // Latency: erase write, draw write on the next cycle, then idle.
    push_wr(tile_map[cursor], ERASE_C);
    push_wr(tile_map[(cursor + 1) % 16], RED_C);
    cursor = (cursor + 1) % 16;
    btnr = 1'b1;
    n = 0;
    while (bus.px_wr !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("lat_erase_wr", {31'd0, bus.px_wr}, 32'd1);
    check("lat_erase_data", {26'd0, bus.mem_px_data}, {26'd0, ERASE_C});
    check("lat_erase_busy", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    check("lat_draw_wr", {31'd0, bus.px_wr}, 32'd1);
    check("lat_draw_addr", {26'd0, bus.mem_px_addr}, tile_map[cursor]);
    check("lat_draw_data", {26'd0, bus.mem_px_data}, {26'd0, RED_C});
    @(negedge clk);
    check("lat_idle_wr", {31'd0, bus.px_wr}, 32'd0);
    check("lat_idle_busy", {31'd0, bus.busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("held_no_repeat", {31'd0, bus.px_wr}, 32'd0);
    btnr = 1'b0;
    repeat (14) @(negedge clk);
    wait_idle();
    check("lat_queue_empty", exp_q.size(), 0);

    // Reset asserted while the draw write is on the outputs.
    push_wr(tile_map[cursor], ERASE_C);
    btnr = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(bus.px_wr === 1'b1 && bus.mem_px_data === RED_C) && n < 40);
    check("mid_draw_seen", {31'd0, bus.px_wr}, 32'd1);
    #1 rst = 1'b1;
    #1 check_reset_vals("mid_reset");
    btnr = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_queue_empty", exp_q.size(), 0);
    cursor = 0;
    push_clear();
    rst = 1'b0;
    @(negedge clk);
    check("restart_wr", {31'd0, bus.px_wr}, 32'd1);
    check("restart_addr", {26'd0, bus.mem_px_addr}, 32'd0);
    wait_idle();
    check("restart_queue_empty", exp_q.size(), 0);

    // Cursor back at slot 0 after the restart.
    push_wr(0, ERASE_C);
    push_wr(16, RED_C);
    @(negedge clk);
    btnr = 1'b1;
    repeat (10) @(negedge clk);
    btnr = 1'b0;
    repeat (14) @(negedge clk);
    wait_idle();
    check("post_reset_queue_empty", exp_q.size(), 0);
    check("post_reset_ram0", {26'd0, ram[0]}, {26'd0, ERASE_C});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish before 200us");
    $fatal(1);
  end
endmodule
